// File: rtl/clock_display_pkg.sv
// Shared types and helpers for the clock display driver: converter FSM states,
// digit/step counts and the active-low 7-segment decode.
package clock_display_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } conv_state_e;

   localparam int NUM_DIGITS = 6;
   localparam int CONV_STEPS = 6;

   // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment. Non-decimal nibbles go dark.
   function automatic logic [6:0] seg7_lut(input logic [3:0] nibble);
      logic [6:0] segs;
      case (nibble)
         4'd0:    segs = 7'h40;
         4'd1:    segs = 7'h79;
         4'd2:    segs = 7'h24;
         4'd3:    segs = 7'h30;
         4'd4:    segs = 7'h19;
         4'd5:    segs = 7'h12;
         4'd6:    segs = 7'h02;
         4'd7:    segs = 7'h78;
         4'd8:    segs = 7'h00;
         4'd9:    segs = 7'h10;
         default: segs = 7'h7F;
      endcase
      return segs;
   endfunction

endpackage

// File: rtl/clock_display_driver_scanner.sv
// Multiplexed display scan: holds each digit lit for REFRESH_DIV cycles and
// drives registered seg/an/dp for the currently selected digit.
module display_scanner
   import clock_display_pkg::*;
#(
   parameter int REFRESH_DIV      = 100000,
   parameter int BLANK_LEADING_HR = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_DIGITS*4-1:0]   digits,
   input  logic                      colon_on,
   output logic [6:0]                seg,
   output logic [5:0]                an,
   output logic                      dp
);

   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [3:0]    nibble;
   logic [6:0]    seg_next;
   logic [5:0]    an_next;
   logic          dp_next;

   always_comb begin
      nibble = 4'd0;
      case (idx)
         3'd0:    nibble = digits[3:0];
         3'd1:    nibble = digits[7:4];
         3'd2:    nibble = digits[11:8];
         3'd3:    nibble = digits[15:12];
         3'd4:    nibble = digits[19:16];
         3'd5:    nibble = digits[23:20];
         default: nibble = 4'd0;
      endcase
      // Leading hour zero is dark but its anode still fires, keeping scan timing uniform.
      if (idx == 3'd5 && BLANK_LEADING_HR != 0 && nibble == 4'd0)
         seg_next = 7'h7F;
      else
         seg_next = seg7_lut(nibble);
      an_next = ~(6'b000001 << idx);
      dp_next = ~(colon_on && (idx == 3'd2 || idx == 3'd4));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
         idx <= 3'd0;
         seg <= 7'h7F;
         an  <= 6'h3F;
         dp  <= 1'b1;
      end else begin
         seg <= seg_next;
         an  <= an_next;
         dp  <= dp_next;
         if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_display_driver.sv
// Time-bus reader: captures hr/min/sec on change, converts to BCD with a
// 6-step shift-add-3 pass, and hands the digits to the display scanner.
module clock_display_driver
   import clock_display_pkg::*;
#(
   parameter int REFRESH_DIV      = 100000,
   parameter int BLANK_LEADING_HR = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hr,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       dp,
   output logic       bcd_valid
);

   conv_state_e state, state_next;

   logic [4:0]  shadow_hr;
   logic [5:0]  shadow_min, shadow_sec;
   logic        force_conv;
   logic [5:0]  bin_hr, bin_min, bin_sec;
   logic [7:0]  bcd_hr, bcd_min, bcd_sec;
   logic [2:0]  step;
   logic [23:0] disp_digits;
   logic        colon_on;
   logic        start;

   function automatic logic [13:0] shift_add3(input logic [7:0] bcd, input logic [5:0] bin);
      logic [7:0] adj;
      adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
      adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
      return {adj, bin} << 1;
   endfunction

   assign start = (state == IDLE) &&
                  (force_conv || {hr, min, sec} != {shadow_hr, shadow_min, shadow_sec});

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CONV;
         CONV:    if (step == 3'(CONV_STEPS - 1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow_hr   <= '0;
         shadow_min  <= '0;
         shadow_sec  <= '0;
         force_conv  <= 1'b1;
         bin_hr      <= '0;
         bin_min     <= '0;
         bin_sec     <= '0;
         bcd_hr      <= '0;
         bcd_min     <= '0;
         bcd_sec     <= '0;
         step        <= '0;
         disp_digits <= '0;
         colon_on    <= 1'b0;
         bcd_valid   <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               shadow_hr  <= hr;
               shadow_min <= min;
               shadow_sec <= sec;
               force_conv <= 1'b0;
               bin_hr     <= {1'b0, hr};
               bin_min    <= min;
               bin_sec    <= sec;
               bcd_hr     <= '0;
               bcd_min    <= '0;
               bcd_sec    <= '0;
               step       <= '0;
            end
            CONV: begin
               {bcd_hr, bin_hr}   <= shift_add3(bcd_hr, bin_hr);
               {bcd_min, bin_min} <= shift_add3(bcd_min, bin_min);
               {bcd_sec, bin_sec} <= shift_add3(bcd_sec, bin_sec);
               step <= step + 3'd1;
            end
            DONE: begin
               // BCD is one-to-one with 0..63, so comparing digits equals comparing seconds.
               if (bcd_sec != disp_digits[7:0]) colon_on <= ~colon_on;
               disp_digits <= {bcd_hr, bcd_min, bcd_sec};
               bcd_valid   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   display_scanner #(
      .REFRESH_DIV      (REFRESH_DIV),
      .BLANK_LEADING_HR (BLANK_LEADING_HR)
   ) u_scanner (
      .clk      (clk),
      .reset    (reset),
      .digits   (disp_digits),
      .colon_on (colon_on),
      .seg      (seg),
      .an       (an),
      .dp       (dp)
   );

endmodule

// File: tb/tb_clock_display_driver.sv
// Bench for clock_display_driver: directed vector table, timing sequences and
// randomized times checked against an arithmetic display model.
module tb_clock_display_driver;

   typedef logic [5:0][6:0] segs_t;
   typedef struct {
      logic [4:0] hr;
      logic [5:0] min;
      logic [5:0] sec;
      segs_t      segs;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] sec = '0;
   logic [5:0] min = '0;
   logic [4:0] hr = '0;
   logic [6:0] seg;
   logic [5:0] an;
   logic       dp;
   logic       bcd_valid;

   int n_checks = 0;
   int n_pass = 0;

   logic [6:0] lut_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int model_prev_sec = 0;
   bit model_colon = 1'b0;

   always #5 clk = ~clk;

   clock_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING_HR(1)) dut (
      .clk(clk), .reset(reset), .sec(sec), .min(min), .hr(hr),
      .seg(seg), .an(an), .dp(dp), .bcd_valid(bcd_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic segs_t model_segs(input int h, input int m, input int s);
      segs_t r;
      r[0] = lut_ref[s % 10];
      r[1] = lut_ref[s / 10];
      r[2] = lut_ref[m % 10];
      r[3] = lut_ref[m / 10];
      r[4] = lut_ref[h % 10];
      r[5] = (h / 10 == 0) ? 7'h7F : lut_ref[h / 10];
      return r;
   endfunction

   task automatic model_display(input int s);
      if (s != model_prev_sec) model_colon = ~model_colon;
      model_prev_sec = s;
   endtask

   task automatic wait_an(input logic [5:0] target, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (an === target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid(input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bcd_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, " bcd_valid seen"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic check_scan(input string name, input segs_t exp);
      bit ok;
      logic [5:0] target;
      for (int i = 0; i < 6; i++) begin
         target = ~(6'b000001 << i);
         wait_an(target, 60, ok);
         if (!ok) begin
            check($sformatf("%s an digit%0d", name, i), {26'd0, an}, {26'd0, target});
         end else begin
            check($sformatf("%s seg digit%0d", name, i), {25'd0, seg}, {25'd0, exp[i]});
            check($sformatf("%s dp digit%0d", name, i), {31'd0, dp},
                  (model_colon && (i == 2 || i == 4)) ? 32'd0 : 32'd1);
         end
      end
   endtask

   task automatic apply_and_verify(input string name, input int h, input int m, input int s,
                                   input segs_t exp);
      @(negedge clk);
      hr = 5'(h); min = 6'(m); sec = 6'(s);
      wait_valid(name);
      model_display(s);
      repeat (2) @(negedge clk);
      check_scan(name, exp);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " an"}, {26'd0, an}, 32'h3F);
      check({name, " seg"}, {25'd0, seg}, 32'h7F);
      check({name, " dp"}, {31'd0, dp}, 32'd1);
      check({name, " bcd_valid"}, {31'd0, bcd_valid}, 32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      int first_k, pulses, h, m, s;
      bit ok;
      logic [5:0] target;

      vecs[0] = '{5'd23, 6'd59, 6'd58, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h00}, "t2359_58"};
      vecs[1] = '{5'd5,  6'd59, 6'd58, {7'h7F, 7'h12, 7'h12, 7'h10, 7'h12, 7'h00}, "hr5_blank"};
      vecs[2] = '{5'd5,  6'd59, 6'd63, {7'h7F, 7'h12, 7'h12, 7'h10, 7'h02, 7'h30}, "sec63"};
      vecs[3] = '{5'd12, 6'd34, 6'd7,  {7'h79, 7'h24, 7'h30, 7'h19, 7'h40, 7'h78}, "t1234_07"};
      vecs[4] = '{5'd10, 6'd0,  6'd9,  {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10}, "hr10"};
      vecs[5] = '{5'd19, 6'd8,  6'd20, {7'h79, 7'h10, 7'h40, 7'h00, 7'h24, 7'h40}, "t1908_20"};

      // Reset held for three edges, then release with 00:00:00.
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;
      first_k = 0;
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bcd_valid === 1'b1) begin
            pulses++;
            if (first_k == 0) first_k = k;
         end
      end
      check("release latency edge", first_k, 8);
      check("release pulse count", pulses, 1);
      model_display(0);
      check_scan("zero", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

      for (int v = 0; v < 6; v++)
         apply_and_verify(vecs[v].name, int'(vecs[v].hr), int'(vecs[v].min),
                          int'(vecs[v].sec), vecs[v].segs);

      // Anode sequence and dwell: catch the first cycle of digit 0.
      wait_an(6'h1F, 60, ok);
      check("scan sync 1F", {31'd0, ok}, 32'd1);
      wait_an(6'h3E, 10, ok);
      check("scan sync 3E", {31'd0, ok}, 32'd1);
      for (int c = 0; c < 24; c++) begin
         target = ~(6'b000001 << (c / 4));
         check($sformatf("an step c%0d", c), {26'd0, an}, {26'd0, target});
         @(negedge clk);
      end

      // Input change during the second conversion cycle must produce a second update.
      @(negedge clk);
      hr = 5'd12; min = 6'd34; sec = 6'd10;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      sec = 6'd11;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bcd_valid === 1'b1) pulses++;
      end
      check("mid-conv pulses", pulses, 2);
      model_display(10);
      model_display(11);
      check_scan("mid-conv", model_segs(12, 34, 11));

      // Randomized times, some keeping seconds so the colon must hold still.
      for (int it = 0; it < 20; it++) begin
         h = int'($urandom_range(0, 23));
         m = int'($urandom_range(0, 59));
         s = ($urandom_range(0, 3) == 0) ? int'(sec) : int'($urandom_range(0, 63));
         if (h == int'(hr) && m == int'(min) && s == int'(sec)) m = (m + 1) % 60;
         apply_and_verify($sformatf("rnd%0d", it), h, m, s, model_segs(h, m, s));
      end

      // Reset in the middle of a conversion and scan.
      @(negedge clk);
      hr = 5'd7; min = 6'd45; sec = 6'd31;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid reset");
      model_prev_sec = 0;
      model_colon = 1'b0;
      reset = 1'b1;
      wait_valid("after reset");
      model_display(31);
      repeat (2) @(negedge clk);
      check_scan("after reset", model_segs(7, 45, 31));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
